// File: rtl/indirect_calc_sched.sv
// ============================================================================
//  Module      : indirect_calc_sched
//  Description : Gauss-Newton iteration scheduler for the IndirectCalc
//                datapath. Streams the stored match list into IndirectCalc
//                once per iteration, holds the pose stable for the frame,
//                waits for the pipeline drain and the solver's pose update,
//                and pulses o_done after the last iteration.
//  Options     : INDIRECT_SCHED_DEPTH_FILTER_EN - entries with zero depth
//                are emitted in their slot with o_valid low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module indirect_calc_sched #(
    parameter int MATCH_BW      = 10,
    parameter int ITER_BW       = 4,
    parameter int RD_LAT        = 1,
    parameter int POSE_BW       = 32,
    parameter int H_SIZE_BW     = 11,
    parameter int V_SIZE_BW     = 10,
    parameter int DATA_DEPTH_BW = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [MATCH_BW-1:0]            i_match_num,
    input  logic [ITER_BW-1:0]             r_iter_num,
    input  logic [11:0][POSE_BW-1:0]       i_pose_init,
    input  logic                           i_pose_update,
    input  logic [11:0][POSE_BW-1:0]       i_pose_new,
    input  logic                           i_calc_frame_end,
    output logic                           o_rd_en,
    output logic [MATCH_BW-1:0]            o_rd_addr,
    input  logic [H_SIZE_BW-1:0]           i_rd_idx0_x,
    input  logic [V_SIZE_BW-1:0]           i_rd_idx0_y,
    input  logic [DATA_DEPTH_BW-1:0]       i_rd_depth0,
    input  logic [H_SIZE_BW-1:0]           i_rd_idx1_x,
    input  logic [V_SIZE_BW-1:0]           i_rd_idx1_y,
    output logic                           o_frame_start,
    output logic                           o_frame_end,
    output logic                           o_valid,
    output logic [H_SIZE_BW-1:0]           o_idx0_x,
    output logic [V_SIZE_BW-1:0]           o_idx0_y,
    output logic [DATA_DEPTH_BW-1:0]       o_depth0,
    output logic [H_SIZE_BW-1:0]           o_idx1_x,
    output logic [V_SIZE_BW-1:0]           o_idx1_y,
    output logic [11:0][POSE_BW-1:0]       o_pose,
    output logic [ITER_BW-1:0]             o_iter_cnt,
    output logic                           o_busy,
    output logic                           o_done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STREAM    = 3'd1,
        S_DRAIN     = 3'd2,
        S_WAIT_POSE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                     state_q;
    logic                       rd_en_q;
    logic [MATCH_BW-1:0]        rd_addr_q;
    logic [MATCH_BW-1:0]        match_num_q;
    logic [ITER_BW-1:0]         iter_cnt_q;
    logic [11:0][POSE_BW-1:0]   pose_q;
    logic                       done_q;

    // Read-tag pipeline: follows each read strobe until its data returns
    logic [RD_LAT-1:0]          tag_vld_q;
    logic [RD_LAT-1:0]          tag_first_q;
    logic [RD_LAT-1:0]          tag_last_q;

    logic                       valid_q;
    logic                       frame_start_q;
    logic                       frame_end_q;
    logic [H_SIZE_BW-1:0]       idx0_x_q;
    logic [V_SIZE_BW-1:0]       idx0_y_q;
    logic [DATA_DEPTH_BW-1:0]   depth0_q;
    logic [H_SIZE_BW-1:0]       idx1_x_q;
    logic [V_SIZE_BW-1:0]       idx1_y_q;

    logic [MATCH_BW-1:0]        w_last_addr;
    logic [ITER_BW-1:0]         w_iter_last;
    logic                       w_tag_first;
    logic                       w_tag_last;
    logic                       w_ret_vld;
    logic                       w_ret_first;
    logic                       w_ret_last;

    // An iteration count of zero behaves as a single iteration
    assign w_last_addr = match_num_q - MATCH_BW'(1);
    assign w_iter_last = (r_iter_num == '0) ? '0 : (r_iter_num - ITER_BW'(1));
    assign w_tag_first = rd_en_q && (rd_addr_q == '0);
    assign w_tag_last  = rd_en_q && (rd_addr_q == w_last_addr);
    assign w_ret_vld   = tag_vld_q[RD_LAT-1];
    assign w_ret_first = tag_first_q[RD_LAT-1];
    assign w_ret_last  = tag_last_q[RD_LAT-1];

    // Job control FSM: read strobes, pose latch, iteration count, done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            match_num_q <= '0;
            iter_cnt_q  <= '0;
            pose_q      <= '0;
            done_q      <= 1'b0;
        end else if (i_abort) begin
            // Pose and iteration count are intentionally preserved
            state_q   <= S_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        pose_q      <= i_pose_init;
                        match_num_q <= i_match_num;
                        iter_cnt_q  <= '0;
                        rd_addr_q   <= '0;
                        if (i_match_num == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_STREAM;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    // Address holds at the last entry; no wrap-around
                    if (rd_addr_q == w_last_addr) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + MATCH_BW'(1);
                    end
                end
                S_DRAIN: begin
                    if (i_calc_frame_end) begin
                        state_q <= S_WAIT_POSE;
                    end
                end
                S_WAIT_POSE: begin
                    if (i_pose_update) begin
                        pose_q <= i_pose_new;
                        if (iter_cnt_q == w_iter_last) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            iter_cnt_q <= iter_cnt_q + ITER_BW'(1);
                            rd_addr_q  <= '0;
                            rd_en_q    <= 1'b1;
                            state_q    <= S_STREAM;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Delay frame markers alongside the read latency; abort drops in-flight reads
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_vld_q   <= '0;
            tag_first_q <= '0;
            tag_last_q  <= '0;
        end else if (i_abort) begin
            tag_vld_q   <= '0;
            tag_first_q <= '0;
            tag_last_q  <= '0;
        end else begin
            tag_vld_q[0]   <= rd_en_q;
            tag_first_q[0] <= w_tag_first;
            tag_last_q[0]  <= w_tag_last;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i]   <= tag_vld_q[i-1];
                tag_first_q[i] <= tag_first_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
            end
        end
    end

    // Register returning match data and its slot flags toward IndirectCalc
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            idx0_x_q      <= '0;
            idx0_y_q      <= '0;
            depth0_q      <= '0;
            idx1_x_q      <= '0;
            idx1_y_q      <= '0;
        end else if (i_abort) begin
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            frame_start_q <= w_ret_vld && w_ret_first;
            frame_end_q   <= w_ret_vld && w_ret_last;
`ifdef INDIRECT_SCHED_DEPTH_FILTER_EN
            // Zero-depth entries keep their slot but are marked invalid
            valid_q       <= w_ret_vld && (i_rd_depth0 != '0);
`else
            valid_q       <= w_ret_vld;
`endif
            if (w_ret_vld) begin
                idx0_x_q <= i_rd_idx0_x;
                idx0_y_q <= i_rd_idx0_y;
                depth0_q <= i_rd_depth0;
                idx1_x_q <= i_rd_idx1_x;
                idx1_y_q <= i_rd_idx1_y;
            end
        end
    end

    assign o_rd_en       = rd_en_q;
    assign o_rd_addr     = rd_addr_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_end   = frame_end_q;
    assign o_valid       = valid_q;
    assign o_idx0_x      = idx0_x_q;
    assign o_idx0_y      = idx0_y_q;
    assign o_depth0      = depth0_q;
    assign o_idx1_x      = idx1_x_q;
    assign o_idx1_y      = idx1_y_q;
    assign o_pose        = pose_q;
    assign o_iter_cnt    = iter_cnt_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_indirect_calc_sched.sv
// ============================================================================
//  Module      : tb_indirect_calc_sched
//  Description : Self-checking bench for indirect_calc_sched with a match
//                buffer model, an IndirectCalc drain model and a job-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_indirect_calc_sched;

    localparam int MATCH_BW = 10;
    localparam int ITER_BW  = 4;
    localparam int RD_LAT   = 1;
    localparam int POSE_BW  = 32;
    localparam int HB       = 11;
    localparam int VB       = 10;
    localparam int DB       = 16;
    localparam int CALC_LAT = 22;
    localparam int POSE_GAP = 5;

    typedef logic [11:0][POSE_BW-1:0] pose_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_abort = 1'b0;
    logic [MATCH_BW-1:0] i_match_num = '0;
    logic [ITER_BW-1:0]  r_iter_num = '0;
    pose_t             i_pose_init = '0;
    logic              i_pose_update = 1'b0;
    pose_t             i_pose_new = '0;
    logic              i_calc_frame_end = 1'b0;
    logic              o_rd_en;
    logic [MATCH_BW-1:0] o_rd_addr;
    logic [HB-1:0]     rd_x0 = '0;
    logic [VB-1:0]     rd_y0 = '0;
    logic [DB-1:0]     rd_d0 = '0;
    logic [HB-1:0]     rd_x1 = '0;
    logic [VB-1:0]     rd_y1 = '0;
    logic              o_frame_start, o_frame_end, o_valid;
    logic [HB-1:0]     o_idx0_x, o_idx1_x;
    logic [VB-1:0]     o_idx0_y, o_idx1_y;
    logic [DB-1:0]     o_depth0;
    pose_t             o_pose;
    logic [ITER_BW-1:0] o_iter_cnt;
    logic              o_busy, o_done;

    int checks = 0;
    int errors = 0;

    // Match buffer contents
    logic [HB-1:0] m_x0 [0:1023];
    logic [VB-1:0] m_y0 [0:1023];
    logic [DB-1:0] m_d0 [0:1023];
    logic [HB-1:0] m_x1 [0:1023];
    logic [VB-1:0] m_y1 [0:1023];

    indirect_calc_sched #(
        .MATCH_BW(MATCH_BW), .ITER_BW(ITER_BW), .RD_LAT(RD_LAT), .POSE_BW(POSE_BW),
        .H_SIZE_BW(HB), .V_SIZE_BW(VB), .DATA_DEPTH_BW(DB)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_match_num(i_match_num), .r_iter_num(r_iter_num), .i_pose_init(i_pose_init),
        .i_pose_update(i_pose_update), .i_pose_new(i_pose_new),
        .i_calc_frame_end(i_calc_frame_end), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_idx0_x(rd_x0), .i_rd_idx0_y(rd_y0), .i_rd_depth0(rd_d0),
        .i_rd_idx1_x(rd_x1), .i_rd_idx1_y(rd_y1),
        .o_frame_start(o_frame_start), .o_frame_end(o_frame_end), .o_valid(o_valid),
        .o_idx0_x(o_idx0_x), .o_idx0_y(o_idx0_y), .o_depth0(o_depth0),
        .o_idx1_x(o_idx1_x), .o_idx1_y(o_idx1_y), .o_pose(o_pose),
        .o_iter_cnt(o_iter_cnt), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency synchronous read buffer
    always @(posedge clk) begin
        if (o_rd_en) begin
            rd_x0 <= m_x0[o_rd_addr];
            rd_y0 <= m_y0[o_rd_addr];
            rd_d0 <= m_d0[o_rd_addr];
            rd_x1 <= m_x1[o_rd_addr];
            rd_y1 <= m_y1[o_rd_addr];
        end
    end

    function automatic void chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic pose_t rand_pose();
        pose_t p;
        for (int i = 0; i < 12; i++) p[i] = $urandom;
        return p;
    endfunction

    function automatic bit exp_valid(input int k);
`ifdef INDIRECT_SCHED_DEPTH_FILTER_EN
        return (m_d0[k] != '0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic fill_mem(input int n);
        for (int i = 0; i < n; i++) begin
            m_x0[i] = HB'($urandom);
            m_y0[i] = VB'($urandom);
            m_x1[i] = HB'($urandom);
            m_y1[i] = VB'($urandom);
            m_d0[i] = ($urandom_range(0, 3) == 0) ? '0 : DB'($urandom_range(1, 65535));
        end
    endtask

    // Runs one job and compares against the job-level expectations
    task automatic run_job(input int n, input int iters, input bit spurious, input string nm);
        pose_t exp_pose;
        int exp_frames, budget, k;
        int rd_seen, first_rd, first_fs, frames, slot, dones, done_cyc, fe_t, pu_t;
        bit in_frame, timeout;
        exp_frames = (n == 0) ? 0 : ((iters == 0) ? 1 : iters);
        budget     = (n + CALC_LAT + POSE_GAP + 10) * (exp_frames + 1) + 20;
        rd_seen = 0; first_rd = -1; first_fs = -1; frames = 0; slot = 0;
        dones = 0; done_cyc = -1; fe_t = 0; pu_t = 0; in_frame = 0; timeout = 1;
        exp_pose = rand_pose();
        @(negedge clk);
        i_match_num = MATCH_BW'(n);
        r_iter_num  = ITER_BW'(iters);
        i_pose_init = exp_pose;
        i_start     = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            i_start = 1'b0; i_calc_frame_end = 1'b0; i_pose_update = 1'b0;
            if (o_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                chk({nm, " rd_addr"}, o_rd_addr, (n == 0) ? 0 : (rd_seen % n));
                rd_seen++;
            end
            if (o_frame_start && !in_frame) begin
                in_frame = 1; slot = 0;
                if (first_fs < 0) first_fs = cyc;
                chk({nm, " iter_cnt"}, o_iter_cnt, frames);
            end
            if (in_frame) begin
                k = slot;
                chk({nm, " slot_valid"}, o_valid, exp_valid(k));
                chk({nm, " slot_start"}, o_frame_start, k == 0);
                chk({nm, " slot_end"}, o_frame_end, k == n - 1);
                chk({nm, " frame_pose"}, o_pose, exp_pose);
                if (exp_valid(k))
                    chk({nm, " slot_data"}, {o_idx0_x, o_idx0_y, o_depth0, o_idx1_x, o_idx1_y},
                        {m_x0[k], m_y0[k], m_d0[k], m_x1[k], m_y1[k]});
                slot++;
                if (o_frame_end || slot >= n) begin
                    in_frame = 0; frames++; fe_t = CALC_LAT;
                end
            end else if (first_fs < 0 || o_valid || o_frame_end) begin
                chk({nm, " stray_out"}, {o_valid, o_frame_end}, 2'b00);
            end
            if (o_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (spurious && cyc == 2) begin
                i_pose_update = 1'b1; i_pose_new = rand_pose(); i_calc_frame_end = 1'b1;
            end else if (fe_t > 0) begin
                fe_t--;
                if (fe_t == 0) begin i_calc_frame_end = 1'b1; pu_t = POSE_GAP; end
            end else if (pu_t > 0) begin
                pu_t--;
                if (pu_t == 0) begin
                    exp_pose = rand_pose(); i_pose_new = exp_pose; i_pose_update = 1'b1;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk({nm, " done_single"}, o_done, 1'b0);
                chk({nm, " idle_after_done"}, o_busy, 1'b0);
                timeout = 0;
                break;
            end
        end
        chk({nm, " timeout"}, timeout, 1'b0);
        chk({nm, " frames"}, frames, exp_frames);
        chk({nm, " done_count"}, dones, 1);
        chk({nm, " rd_count"}, rd_seen, n * exp_frames);
        chk({nm, " final_pose"}, o_pose, exp_pose);
        if (n == 0) begin
            chk({nm, " done_cycle"}, done_cyc, 1);
            chk({nm, " no_frame"}, first_fs, -1);
        end else begin
            chk({nm, " first_rd_cycle"}, first_rd, 1);
            chk({nm, " first_valid_cycle"}, first_fs, 3);
            chk({nm, " last_iter_cnt"}, o_iter_cnt, exp_frames - 1);
        end
    endtask

    initial begin
        pose_t p;
        int n, it;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", {o_rd_en, o_valid, o_frame_start, o_frame_end, o_busy, o_done}, 6'b0);
        chk("reset_pose", o_pose, '0);
        chk("reset_cnts", {o_iter_cnt, o_rd_addr}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", o_busy, 1'b0);

        // N=4, two iterations
        fill_mem(4);
        run_job(4, 2, 1'b0, "n4_it2");

        // N=1, iteration count 0 -> one iteration
        fill_mem(1);
        run_job(1, 0, 1'b0, "n1_it0");

        // Empty match list
        run_job(0, 3, 1'b0, "n0");

        // Spurious pose update and frame end while streaming
        fill_mem(4);
        run_job(4, 1, 1'b1, "spurious");

        // Depth pattern 5,0,7,0
        fill_mem(4);
        m_d0[0] = 16'd5; m_d0[1] = 16'd0; m_d0[2] = 16'd7; m_d0[3] = 16'd0;
        run_job(4, 1, 1'b0, "depth_pat");

        // Abort on the third STREAM cycle
        fill_mem(8);
        p = rand_pose();
        @(negedge clk);
        i_match_num = 10'd8; r_iter_num = 4'd1; i_pose_init = p; i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        @(negedge clk);
        @(negedge clk); i_abort = 1'b1;
        @(negedge clk); i_abort = 1'b0;
        chk("abort_next", {o_busy, o_rd_en, o_valid, o_frame_start, o_frame_end, o_done}, 6'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_quiet", {o_busy, o_rd_en, o_valid, o_frame_start, o_frame_end, o_done}, 6'b0);
        end
        chk("abort_pose_kept", o_pose, p);
        run_job(8, 1, 1'b0, "post_abort");

        // Start and abort together: abort wins
        @(negedge clk);
        i_match_num = 10'd3; r_iter_num = 4'd1; i_start = 1'b1; i_abort = 1'b1;
        @(negedge clk); i_start = 1'b0; i_abort = 1'b0;
        chk("start_abort_same", {o_busy, o_rd_en}, 2'b00);
        @(negedge clk);
        chk("start_abort_quiet", {o_busy, o_rd_en, o_done}, 3'b000);

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            n  = $urandom_range(1, 12);
            it = $urandom_range(0, 3);
            fill_mem(n);
            run_job(n, it, 1'b0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
